// File: rtl/addertree_final.sv
// addertree_final: column popcount, weighted sum, shift/saturate, 3-stage valid/ready pipe.
// Build option: define ADDERTREE_FINAL_RELU_EN to clamp negative sums to zero on q_out.
module addertree_final #(
  parameter int SHIFT = 7,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ao18,
  input  logic [1:0]       ao17,
  input  logic [2:0]       ao16,
  input  logic [4:0]       ao15,
  input  logic [4:0]       ao14,
  input  logic [6:0]       ao13,
  input  logic [8:0]       ao12,
  input  logic [9:0]       ao11,
  input  logic [10:0]      ao10,
  input  logic [11:0]      ao9,
  input  logic [10:0]      ao8,
  input  logic [9:0]       ao7,
  input  logic [9:0]       ao6,
  input  logic [8:0]       ao5,
  input  logic [7:0]       ao4,
  input  logic [5:0]       ao3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [18:0]      sum_out,
  output logic [7:0]       q_out,
  output logic             sat_flag,
  output logic [CNT_W-1:0] sat_cnt
);

  localparam logic signed [18:0] QMAX = 19'sd127;
  localparam logic signed [18:0] QMIN = -19'sd128;

  logic v1_q, v2_q, v3_q;
  logic ld1, ld2, ld3;
  logic [3:0] cnt_d [18:3];
  logic [3:0] cnt_q [18:3];
  logic [18:0] sum_d;
  logic signed [18:0] sum_q;
  logic signed [18:0] sh;
  logic [18:0] sum_o_q;
  logic [7:0] q_d, q_q;
  logic sat_d, sat_q;
  logic [CNT_W-1:0] scnt_q;

  function automatic logic [3:0] pop12(input logic [11:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 12; i++) begin
      c = c + 4'(v[i]);
    end
    return c;
  endfunction

  // A stage may load when empty or when its successor drains it.
  assign ld3 = !v3_q || out_ready;
  assign ld2 = !v2_q || ld3;
  assign ld1 = !v1_q || ld2;
  assign in_ready = ld1;

  always_comb begin
    cnt_d[18] = pop12({11'b0, ao18});
    cnt_d[17] = pop12({10'b0, ao17});
    cnt_d[16] = pop12({9'b0, ao16});
    cnt_d[15] = pop12({7'b0, ao15});
    cnt_d[14] = pop12({7'b0, ao14});
    cnt_d[13] = pop12({5'b0, ao13});
    cnt_d[12] = pop12({3'b0, ao12});
    cnt_d[11] = pop12({2'b0, ao11});
    cnt_d[10] = pop12({1'b0, ao10});
    cnt_d[9]  = pop12(ao9);
    cnt_d[8]  = pop12({1'b0, ao8});
    cnt_d[7]  = pop12({2'b0, ao7});
    cnt_d[6]  = pop12({2'b0, ao6});
    cnt_d[5]  = pop12({3'b0, ao5});
    cnt_d[4]  = pop12({4'b0, ao4});
    cnt_d[3]  = pop12({6'b0, ao3});
  end

  always_comb begin
    sum_d = '0;
    for (int n = 3; n <= 18; n++) begin
      sum_d = sum_d + ({15'b0, cnt_q[n]} << n);
    end
  end

  always_comb begin
    sh    = sum_q >>> SHIFT;
    q_d   = sh[7:0];
    sat_d = 1'b0;
    if (sh > QMAX) begin
      q_d   = 8'h7f;
      sat_d = 1'b1;
    end else if (sh < QMIN) begin
      q_d   = 8'h80;
      sat_d = 1'b1;
    end
`ifdef ADDERTREE_FINAL_RELU_EN
    if (sum_q[18]) begin
      q_d   = '0;
      sat_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      for (int n = 3; n <= 18; n++) begin
        cnt_q[n] <= '0;
      end
      sum_q   <= '0;
      sum_o_q <= '0;
      q_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      if (ld1) begin
        v1_q <= in_valid;
        if (in_valid) cnt_q <= cnt_d;
      end
      if (ld2) begin
        v2_q <= v1_q;
        if (v1_q) sum_q <= $signed(sum_d);
      end
      if (ld3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          sum_o_q <= sum_q;
          q_q     <= q_d;
          sat_q   <= sat_d;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scnt_q <= '0;
    end else if (v3_q && out_ready && sat_q && (scnt_q != '1)) begin
      scnt_q <= scnt_q + 1'b1;
    end
  end

  assign out_valid = v3_q;
  assign sum_out   = sum_o_q;
  assign q_out     = q_q;
  assign sat_flag  = sat_q;
  assign sat_cnt   = scnt_q;

endmodule
